// File: rtl/aux_mailbox_pkg.sv
// Shared definitions for the control/host mailbox: FSM encoding and width helpers.
package aux_mailbox_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR_WAIT = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel index width; a single channel still needs one select bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? clog2(num_ch) : 1;
    endfunction

    // Usage count must represent both 0 and DEPTH.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    localparam int DEF_CH_W  = ch_w(4);
    localparam int DEF_CNT_W = cnt_w(1024);

endpackage

// File: rtl/aux_fifo_sc.sv
// Single-clock FIFO with registered read port, usage count, full and empty.
module aux_fifo_sc
    import aux_mailbox_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic [DATA_W-1:0]        dout_o,
    output logic [cnt_w(DEPTH)-1:0]  used_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     used_q;
    logic [DATA_W-1:0] dout_q;
    logic              do_push_s;
    logic              do_pop_s;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        do_pop_s  = pop_i && (used_q != {CW{1'b0}});
        do_push_s = push_i && ((used_q != CW'(DEPTH)) || do_pop_s);
    end

    // storage array
    always_ff @(posedge clk) begin
        if (do_push_s && !reset) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // pointers, usage count and read register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            used_q   <= {CW{1'b0}};
            dout_q   <= {DATA_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                dout_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push_s, do_pop_s})
                2'b10:   used_q <= used_q + CW'(1);
                2'b01:   used_q <= used_q - CW'(1);
                default: used_q <= used_q;
            endcase
        end
    end

    assign dout_o  = dout_q;
    assign used_o  = used_q;
    assign full_o  = (used_q == CW'(DEPTH));
    assign empty_o = (used_q == {CW{1'b0}});

endmodule

// File: rtl/aux_mailbox.sv
// Control/host mailbox: per-channel in/out FIFOs plus a control request FSM.
// Optional wait-state timeout is enabled by defining AUX_MAILBOX_TIMEOUT_EN.
module aux_mailbox
    import aux_mailbox_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int NUM_CH      = 4,
    parameter int RD_BLOCK    = 4,
    parameter int WR_BLOCK    = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_req,
    input  logic                     read_req,
    input  logic [ch_w(NUM_CH)-1:0]  channel,
    input  logic [DATA_W-1:0]        data_write,
    output logic [DATA_W-1:0]        data_read,
    output logic                     busy,
    output logic                     err,
    input  logic                     host_rd,
    input  logic [ch_w(NUM_CH)-1:0]  host_rd_ch,
    output logic [DATA_W-1:0]        host_dout,
    output logic [NUM_CH-1:0]        host_rd_ready,
    input  logic                     host_wr,
    input  logic [ch_w(NUM_CH)-1:0]  host_wr_ch,
    input  logic [DATA_W-1:0]        host_din,
    output logic [NUM_CH-1:0]        host_wr_ready,
    output logic [NUM_CH-1:0]        ovf,
    output logic [NUM_CH-1:0]        udf
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int CW   = cnt_w(DEPTH);

    if (NUM_CH < 1 || NUM_CH > 16 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
        RD_BLOCK > DEPTH || WR_BLOCK > DEPTH || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("aux_mailbox: illegal parameter combination");
    end

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, ch_sel_s, host_ch_q;
    logic [DATA_W-1:0] wdata_q, wdata_d, data_read_q, data_read_d;
    logic              busy_q, busy_d, err_q, err_d;
    logic              ch_ok_s, ctl_pop_s, ctl_push_s, to_hit_s;
    logic [NUM_CH-1:0] ovf_q, udf_q, rd_ready_q, wr_ready_q;

    logic [NUM_CH-1:0] in_push_s, in_pop_s, in_full_s, in_empty_s;
    logic [NUM_CH-1:0] out_push_s, out_pop_s, out_full_s, out_empty_s;
    logic [NUM_CH-1:0] ovf_set_s, udf_set_s, rd_ready_s, wr_ready_s, host_pop_ok_s;
    logic [DATA_W-1:0] in_dout_s  [NUM_CH];
    logic [DATA_W-1:0] out_dout_s [NUM_CH];
    logic [CW-1:0]     in_used_s  [NUM_CH];
    logic [CW-1:0]     out_used_s [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Out-of-range host channels match no index and are therefore dropped.
        assign in_push_s[c]     = host_wr && (host_wr_ch == CH_W'(c));
        assign in_pop_s[c]      = ctl_pop_s && (ch_sel_s == CH_W'(c));
        assign out_push_s[c]    = ctl_push_s && (ch_sel_s == CH_W'(c));
        assign out_pop_s[c]     = host_rd && (host_rd_ch == CH_W'(c));
        assign ovf_set_s[c]     = in_push_s[c] && in_full_s[c] && !in_pop_s[c];
        assign udf_set_s[c]     = out_pop_s[c] && out_empty_s[c];
        assign host_pop_ok_s[c] = out_pop_s[c] && !out_empty_s[c];
        assign rd_ready_s[c]    = (out_used_s[c] >= CW'(RD_BLOCK));
        assign wr_ready_s[c]    = ((CW'(DEPTH) - in_used_s[c]) >= CW'(WR_BLOCK));

        aux_fifo_sc #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
            .clk(clk), .reset(reset), .push_i(in_push_s[c]), .pop_i(in_pop_s[c]),
            .din_i(host_din), .dout_o(in_dout_s[c]), .used_o(in_used_s[c]),
            .full_o(in_full_s[c]), .empty_o(in_empty_s[c])
        );

        aux_fifo_sc #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
            .clk(clk), .reset(reset), .push_i(out_push_s[c]), .pop_i(out_pop_s[c]),
            .din_i(wdata_q), .dout_o(out_dout_s[c]), .used_o(out_used_s[c]),
            .full_o(out_full_s[c]), .empty_o(out_empty_s[c])
        );
    end

`ifdef AUX_MAILBOX_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] wait_cnt_q;

    // cycles spent in the current wait state, cleared outside the wait states
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= {TW{1'b0}};
        end else if (state_q == RD_WAIT || state_q == WR_WAIT) begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
        end else begin
            wait_cnt_q <= {TW{1'b0}};
        end
    end

    assign to_hit_s = (state_q == RD_WAIT || state_q == WR_WAIT) &&
                      (wait_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    assign to_hit_s = 1'b0;
`endif

    // A latched out-of-range channel is parked on channel 0 so it never indexes past NUM_CH.
    always_comb begin
        ch_ok_s = (int'(ch_q) < NUM_CH);
        if (ch_ok_s) begin
            ch_sel_s = ch_q;
        end else begin
            ch_sel_s = {CH_W{1'b0}};
        end
    end

    // control FSM next state and request outcome
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        err_d       = err_q;
        data_read_d = data_read_q;
        ctl_pop_s   = 1'b0;
        ctl_push_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_req) begin
                    state_d = RD_WAIT;
                    ch_d    = channel;
                    busy_d  = 1'b1;
                end else if (write_req) begin
                    state_d = WR_WAIT;
                    ch_d    = channel;
                    wdata_d = data_write;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (!ch_ok_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (state_q == RD_WAIT && !in_empty_s[ch_sel_s]) begin
                    ctl_pop_s = 1'b1;
                    state_d   = RD_DATA;
                end else if (state_q == WR_WAIT && !out_full_s[ch_sel_s]) begin
                    ctl_push_s = 1'b1;
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    err_d      = 1'b0;
                end else if (to_hit_s) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    data_read_d = {DATA_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            RD_DATA: begin
                data_read_d = in_dout_s[ch_sel_s];
                err_d       = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // control FSM and request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= {CH_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            data_read_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            data_read_q <= data_read_d;
        end
    end

    // host-side sticky flags, readiness and last popped channel
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q      <= {NUM_CH{1'b0}};
            udf_q      <= {NUM_CH{1'b0}};
            rd_ready_q <= {NUM_CH{1'b0}};
            wr_ready_q <= {NUM_CH{1'b1}};
            host_ch_q  <= {CH_W{1'b0}};
        end else begin
            ovf_q      <= ovf_q | ovf_set_s;
            udf_q      <= udf_q | udf_set_s;
            rd_ready_q <= rd_ready_s;
            wr_ready_q <= wr_ready_s;
            if (|host_pop_ok_s) begin
                host_ch_q <= host_rd_ch;
            end
        end
    end

    // Each FIFO read register only moves on its own pop, so this mux holds on an empty pop.
    assign host_dout     = out_dout_s[host_ch_q];
    assign data_read     = data_read_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign host_rd_ready = rd_ready_q;
    assign host_wr_ready = wr_ready_q;
    assign ovf           = ovf_q;
    assign udf           = udf_q;

endmodule

// File: tb/tb_aux_mailbox.sv
// Scoreboard bench for aux_mailbox: stimulus queues expected responses, a negedge monitor checks them.
module tb_aux_mailbox;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int NUM_CH = 5;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              write_req = 1'b0, read_req = 1'b0;
    logic [CH_W-1:0]   channel = '0;
    logic [DATA_W-1:0] data_write = '0;
    logic [DATA_W-1:0] data_read;
    logic              busy, err;
    logic              host_rd = 1'b0;
    logic [CH_W-1:0]   host_rd_ch = '0;
    logic [DATA_W-1:0] host_dout;
    logic [NUM_CH-1:0] host_rd_ready, host_wr_ready, ovf, udf;
    logic              host_wr = 1'b0;
    logic [CH_W-1:0]   host_wr_ch = '0;
    logic [DATA_W-1:0] host_din = '0;

    aux_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .RD_BLOCK(4),
                  .WR_BLOCK(512), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .write_req(write_req), .read_req(read_req),
        .channel(channel), .data_write(data_write), .data_read(data_read),
        .busy(busy), .err(err), .host_rd(host_rd), .host_rd_ch(host_rd_ch),
        .host_dout(host_dout), .host_rd_ready(host_rd_ready), .host_wr(host_wr),
        .host_wr_ch(host_wr_ch), .host_din(host_din), .host_wr_ready(host_wr_ready),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        int                fall_cyc;
    } ctl_exp_t;

    ctl_exp_t          ctl_q[$];
    logic [DATA_W-1:0] host_q[$];
    logic [DATA_W-1:0] model_dr = '0;
    logic [DATA_W-1:0] model_hd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: host pops compare one cycle after the strobe, control results when busy falls
    logic     busy_prev = 1'b0, rst_prev = 1'b1, hpop_pend = 1'b0;
    ctl_exp_t e;
    always @(negedge clk) begin
        if (hpop_pend) begin
            if (host_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL host_unexpected: pop with no expectation at cycle %0d", cyc);
            end else begin
                check("host_dout", host_dout, host_q.pop_front());
            end
        end
        hpop_pend = host_rd;
        if (busy_prev && !busy && !rst_prev) begin
            if (ctl_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ctl_unexpected: busy fell with no request at cycle %0d", cyc);
            end else begin
                e = ctl_q.pop_front();
                check("data_read", data_read, e.data);
                check("err", err, e.err);
                check("busy_fall_cycle", cyc, e.fall_cyc);
            end
        end
        busy_prev = busy;
        rst_prev  = reset;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int i;
        i = 0;
        while (busy && i < limit) begin
            tick();
            i++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, limit);
        end
    endtask

    task automatic ctl_read(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d,
                            input logic e_err, input int lat);
        read_req = 1'b1;
        channel  = ch;
        ctl_q.push_back('{d, e_err, cyc + lat});
        tick();
        read_req = 1'b0;
        wait_idle("ctl_read_done", 100);
        model_dr = d;
    endtask

    task automatic ctl_write(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        write_req  = 1'b1;
        channel    = ch;
        data_write = d;
        ctl_q.push_back('{model_dr, 1'b0, cyc + 2});
        tick();
        write_req = 1'b0;
        wait_idle("ctl_write_done", 100);
    endtask

    task automatic host_push(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        host_wr    = 1'b1;
        host_wr_ch = ch;
        host_din   = d;
        tick();
        host_wr = 1'b0;
    endtask

    task automatic host_pop(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        host_rd    = 1'b1;
        host_rd_ch = ch;
        host_q.push_back(d);
        model_hd = d;
        tick();
        host_rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_data_read", data_read, 0);
        check("rst_host_dout", host_dout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);
        check("rst_rd_ready", host_rd_ready, 5'b00000);
        check("rst_wr_ready", host_wr_ready, 5'b11111);

        // host to control on ch2, three-cycle read latency
        host_push(3'd2, 32'hA5A5_0001);
        ctl_read(3'd2, 32'hA5A5_0001, 1'b0, 3);

        // control to host on ch1 with the RD_BLOCK threshold and one-cycle lag
        for (int k = 0; k < 4; k++) ctl_write(3'd1, 32'h10 + k);
        check("rd_ready_lag", host_rd_ready[1], 1'b0);
        tick();
        check("rd_ready_set", host_rd_ready[1], 1'b1);
        for (int k = 0; k < 4; k++) host_pop(3'd1, 32'h10 + k);
        tick(2);
        check("udf_after_pops", udf, 5'b00000);
        host_pop(3'd1, model_hd);
        tick();
        check("udf_empty_pop", udf, 5'b00010);
        host_pop(3'd7, model_hd);
        host_push(3'd6, 32'hDEAD_BEEF);
        tick();
        check("udf_bad_host_ch", udf, 5'b00010);
        check("ovf_bad_host_ch", ovf, 5'b00000);

        // simultaneous read and write on a valid channel: read wins, write dropped
        host_push(3'd2, 32'h0000_BEEF);
        read_req = 1'b1; write_req = 1'b1; channel = 3'd2; data_write = 32'h5555;
        ctl_q.push_back('{32'h0000_BEEF, 1'b0, cyc + 3});
        tick();
        read_req = 1'b0; write_req = 1'b0;
        wait_idle("rd_wins_done", 100);
        model_dr = 32'h0000_BEEF;
        host_pop(3'd2, model_hd);
        tick();
        check("write_discarded", udf, 5'b00110);

        // out-of-range control channel: one busy cycle, err set, nothing touched
        read_req = 1'b1; write_req = 1'b1; channel = 3'd5;
        ctl_q.push_back('{model_dr, 1'b1, cyc + 2});
        tick();
        read_req = 1'b0; write_req = 1'b0;
        wait_idle("bad_ch_done", 100);
        check("bad_ch_rd_ready", host_rd_ready, 5'b00000);

        // fill ch0 in-FIFO: WR_BLOCK threshold, overflow drops word 1025
        for (int i = 0; i < 512; i++) host_push(3'd0, i);
        tick();
        check("wr_ready_512", host_wr_ready[0], 1'b1);
        host_push(3'd0, 32'd512);
        tick();
        check("wr_ready_513", host_wr_ready[0], 1'b0);
        for (int i = 513; i < 1024; i++) host_push(3'd0, i);
        check("ovf_at_full", ovf, 5'b00000);
        host_push(3'd0, 32'd1024);
        check("ovf_set", ovf, 5'b00001);
        for (int i = 0; i < 1024; i++) ctl_read(3'd0, i, 1'b0, 3);
        host_push(3'd0, 32'hDEAD_0000);
        ctl_read(3'd0, 32'hDEAD_0000, 1'b0, 3);

        // full ch4: host push in the same cycle as the control pop must succeed
        for (int i = 0; i < 1024; i++) host_push(3'd4, 32'h4000 + i);
        read_req = 1'b1; channel = 3'd4;
        ctl_q.push_back('{32'h4000, 1'b0, cyc + 3});
        tick();
        read_req = 1'b0;
        host_push(3'd4, 32'h4FFF);
        wait_idle("push_pop_done", 100);
        model_dr = 32'h4000;
        check("ovf_push_pop", ovf, 5'b00001);
        host_push(3'd4, 32'h5000);
        check("ovf_still_full", ovf, 5'b10001);

        // fill ch0 out-FIFO, then reset while the next write waits
        for (int i = 0; i < 1024; i++) ctl_write(3'd0, 32'h7000 + i);
        tick();
        check("rd_ready_full", host_rd_ready[0], 1'b1);
        write_req = 1'b1; channel = 3'd0; data_write = 32'hBAD0_0BAD;
        tick();
        write_req = 1'b0;
        tick(2);
        check("wr_wait_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_dr = '0;
        model_hd = '0;
        check("abort_busy", busy, 1'b0);
        check("abort_wr_ready", host_wr_ready, 5'b11111);
        check("abort_rd_ready", host_rd_ready, 5'b00000);
        check("abort_flags", {ovf, udf}, 10'd0);
        tick(5);
        host_pop(3'd0, model_hd);
        tick();
        check("abort_ch0_empty", udf, 5'b00001);

        // read of an empty channel: timeout or indefinite wait
        host_push(3'd2, 32'h77);
        ctl_read(3'd2, 32'h77, 1'b0, 3);
`ifdef AUX_MAILBOX_TIMEOUT_EN
        ctl_read(3'd3, 32'h0, 1'b1, 17);
`else
        read_req = 1'b1; channel = 3'd3;
        tick();
        read_req = 1'b0;
        tick(40);
        check("rd_wait_holds", busy, 1'b1);
        ctl_q.push_back('{32'h33, 1'b0, cyc + 3});
        host_push(3'd3, 32'h33);
        wait_idle("late_data_done", 100);
`endif

        tick(3);
        check("ctl_q_left", ctl_q.size(), 0);
        check("host_q_left", host_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
